// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths, writeback request type and grant encoding
package rf_wb_pkg;

  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  typedef enum logic {
    GRANT_LSU = 1'b0,
    GRANT_ALU = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-response queue with per-entry rd visibility for hazard lookup
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                push_i,
  input  T                                    push_data_i,
  input  logic                                pop_i,
  output T                                    head_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [DEPTH-1:0]                    entry_valid_o,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]     entry_rd_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes a full queue from an empty one.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count;
  logic          push_en, pop_en;
  logic [AW-1:0] offset;
  T              mem_q [DEPTH];

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    offset        = '0;
    entry_valid_o = '0;
    entry_rd_o    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset           = AW'(i) - rd_ptr_q[AW-1:0];
      entry_valid_o[i] = ({1'b0, offset} < count);
      entry_rd_o[i]    = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin ALU/LSU writeback arbiter with registered RF write port
module wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [RF_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]      alu_data_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [RF_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]      lsu_data_i,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  input  logic [RF_ADDR_W-1:0] query_rd_i,
  output logic                 query_hit_o
);

  wb_req_t                                lsu_req, fifo_head, win_req;
  logic                                   fifo_full, fifo_empty, fifo_nonempty;
  logic                                   lsu_push, grant_lsu, grant_alu, fifo_hit;
  logic [FIFO_DEPTH-1:0]                  entry_valid;
  logic [FIFO_DEPTH-1:0][RF_ADDR_W-1:0]   entry_rd;

  grant_e                 last_grant_q, last_grant_d;
  logic                   rf_we_q, rf_we_d;
  logic [RF_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]        rf_wdata_q, rf_wdata_d;

  assign lsu_req.rd   = lsu_rd_i;
  assign lsu_req.data = lsu_data_i;

  assign fifo_nonempty = !fifo_empty;
  assign lsu_ready_o   = !fifo_full;
  assign lsu_push      = lsu_valid_i && !fifo_full && !rst_i;
  assign alu_ready_o   = !(fifo_nonempty && last_grant_q == GRANT_ALU);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (wb_req_t)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (lsu_push),
    .push_data_i   (lsu_req),
    .pop_i         (grant_lsu),
    .head_o        (fifo_head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_rd_o    (entry_rd)
  );

  // The FIFO head wins a tie only when the ALU had the previous grant.
  always_comb begin
    grant_lsu    = fifo_nonempty && (!alu_valid_i || last_grant_q == GRANT_ALU);
    grant_alu    = alu_valid_i && !grant_lsu;
    win_req      = grant_lsu ? fifo_head : '{rd: alu_rd_i, data: alu_data_i};
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (grant_lsu || grant_alu) begin
      last_grant_d = grant_lsu ? GRANT_LSU : GRANT_ALU;
      rf_we_d      = (win_req.rd != '0);
      rf_waddr_d   = win_req.rd;
      rf_wdata_d   = win_req.data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= GRANT_LSU;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] && entry_rd[i] == query_rd_i) fifo_hit = 1'b1;
    end
  end

  assign query_hit_o = (query_rd_i != '0) &&
                       (fifo_hit || (rf_we_q && rf_waddr_q == query_rd_i));

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed scenarios with a queue-level reference model checked every cycle
module tb_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        alu_valid_i, lsu_valid_i;
  logic [4:0]  alu_rd_i, lsu_rd_i, query_rd_i;
  logic [31:0] alu_data_i, lsu_data_i;
  logic        alu_ready_o, lsu_ready_o, rf_we_o, query_hit_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_ready_o (alu_ready_o),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_rd_i    (lsu_rd_i),
    .lsu_data_i  (lsu_data_i),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .query_rd_i  (query_rd_i),
    .query_hit_o (query_hit_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending loads plus who was served last.
  wb_req_t     m_fifo[$];
  bit          m_last_alu;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          chk_en = 0;
  bit          m_take_lsu, m_take_alu, m_hit;
  wb_req_t     m_r;
  logic [4:0]  wr_log[$];

  always @(posedge clk) begin
    if (rst_i) begin
      m_fifo.delete();
      m_last_alu = 0;
      m_we = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      m_take_lsu = (m_fifo.size() != 0) && (!alu_valid_i || m_last_alu);
      m_take_alu = alu_valid_i && !m_take_lsu;
      if (lsu_valid_i && m_fifo.size() < DEPTH) begin
        m_r.rd = lsu_rd_i; m_r.data = lsu_data_i;
        m_fifo.push_back(m_r);
      end
      if (m_take_lsu) begin
        m_r = m_fifo.pop_front();
        m_we = (m_r.rd != 0); m_waddr = m_r.rd; m_wdata = m_r.data; m_last_alu = 0;
      end else if (m_take_alu) begin
        m_we = (alu_rd_i != 0); m_waddr = alu_rd_i; m_wdata = alu_data_i; m_last_alu = 1;
      end else begin
        m_we = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_hit = 0;
      foreach (m_fifo[i]) if (m_fifo[i].rd == query_rd_i) m_hit = 1;
      if (m_we && m_waddr == query_rd_i) m_hit = 1;
      if (query_rd_i == 0) m_hit = 0;
      chk("m_lsu_ready", {31'b0, lsu_ready_o}, {31'b0, m_fifo.size() < DEPTH});
      chk("m_alu_ready", {31'b0, alu_ready_o}, {31'b0, !(m_fifo.size() != 0 && m_last_alu)});
      chk("m_rf_we", {31'b0, rf_we_o}, {31'b0, m_we});
      chk("m_rf_waddr", {27'b0, rf_waddr_o}, {27'b0, m_waddr});
      chk("m_rf_wdata", rf_wdata_o, m_wdata);
      chk("m_query_hit", {31'b0, query_hit_o}, {31'b0, m_hit});
      if (rf_we_o === 1'b1) wr_log.push_back(rf_waddr_o);
    end
  end

  wb_req_t alu_tx[$], lsu_tx[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alu_valid_i = 0; alu_rd_i = '0; alu_data_i = '0;
    lsu_valid_i = 0; lsu_rd_i = '0; lsu_data_i = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  task automatic add_tx(input bit to_lsu, input logic [4:0] rd, input logic [31:0] data);
    wb_req_t r;
    r.rd = rd; r.data = data;
    if (to_lsu) lsu_tx.push_back(r); else alu_tx.push_back(r);
  endtask

  // Presents queue heads each cycle, retiring an item only when its handshake completes.
  task automatic run_stream(input int max_cyc, output int lsu_at_full);
    int  cyc = 0;
    int  lsu_acc = 0;
    bit  a_acc, l_acc;
    lsu_at_full = -1;
    while ((alu_tx.size() != 0 || lsu_tx.size() != 0) && cyc < max_cyc) begin
      alu_valid_i = (alu_tx.size() != 0);
      if (alu_valid_i) begin alu_rd_i = alu_tx[0].rd; alu_data_i = alu_tx[0].data; end
      lsu_valid_i = (lsu_tx.size() != 0);
      if (lsu_valid_i) begin lsu_rd_i = lsu_tx[0].rd; lsu_data_i = lsu_tx[0].data; end
      a_acc = alu_valid_i && alu_ready_o;
      l_acc = lsu_valid_i && lsu_ready_o;
      if (lsu_valid_i && !lsu_ready_o && lsu_at_full < 0) lsu_at_full = lsu_acc;
      tick();
      if (a_acc) void'(alu_tx.pop_front());
      if (l_acc) begin void'(lsu_tx.pop_front()); lsu_acc++; end
      cyc++;
    end
    set_idle();
  endtask

  int full_at;
  int li, ai;

  initial begin
    query_rd_i = '0;
    do_reset();
    chk_en = 1;
    chk("rst_we", {31'b0, rf_we_o}, 32'd0);
    chk("rst_waddr", {27'b0, rf_waddr_o}, 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_lsu_ready", {31'b0, lsu_ready_o}, 32'd1);
    chk("rst_alu_ready", {31'b0, alu_ready_o}, 32'd1);

    // ALU only
    alu_valid_i = 1; alu_rd_i = 5'd5; alu_data_i = 32'h1234;
    chk("alu_ready_c0", {31'b0, alu_ready_o}, 32'd1);
    tick(); set_idle();
    chk("alu_we_c1", {31'b0, rf_we_o}, 32'd1);
    chk("alu_waddr_c1", {27'b0, rf_waddr_o}, 32'd5);
    chk("alu_wdata_c1", rf_wdata_o, 32'h1234);
    tick();
    chk("alu_we_c2", {31'b0, rf_we_o}, 32'd0);
    chk("alu_hold_c2", rf_wdata_o, 32'h1234);

    // LSU only, with hazard query on rd 7
    do_reset();
    query_rd_i = 5'd7;
    lsu_valid_i = 1; lsu_rd_i = 5'd7; lsu_data_i = 32'hCAFE;
    chk("lsu_hit_c0", {31'b0, query_hit_o}, 32'd0);
    tick(); set_idle();
    chk("lsu_hit_c1", {31'b0, query_hit_o}, 32'd1);
    chk("lsu_we_c1", {31'b0, rf_we_o}, 32'd0);
    tick();
    chk("lsu_hit_c2", {31'b0, query_hit_o}, 32'd1);
    chk("lsu_we_c2", {31'b0, rf_we_o}, 32'd1);
    chk("lsu_waddr_c2", {27'b0, rf_waddr_o}, 32'd7);
    chk("lsu_wdata_c2", rf_wdata_o, 32'hCAFE);
    tick();
    chk("lsu_hit_c3", {31'b0, query_hit_o}, 32'd0);
    query_rd_i = '0;

    // Contention: alternation starts with the ALU after reset
    do_reset();
    wr_log.delete();
    add_tx(0, 5'd10, 32'hA0); add_tx(0, 5'd11, 32'hA1); add_tx(0, 5'd12, 32'hA2);
    add_tx(1, 5'd3, 32'hB3);  add_tx(1, 5'd4, 32'hB4);
    run_stream(20, full_at);
    tick(); tick();
    chk("cont_count", wr_log.size(), 32'd5);
    if (wr_log.size() == 5) begin
      chk("cont_w0", {27'b0, wr_log[0]}, 32'd10);
      chk("cont_w1", {27'b0, wr_log[1]}, 32'd3);
      chk("cont_w2", {27'b0, wr_log[2]}, 32'd11);
      chk("cont_w3", {27'b0, wr_log[3]}, 32'd4);
      chk("cont_w4", {27'b0, wr_log[4]}, 32'd12);
    end

    // Full queue with ALU saturating; also wraps the pointers
    do_reset();
    wr_log.delete();
    for (int i = 0; i < 10; i++) begin
      add_tx(1, 5'(1 + i), 32'h100 * (i + 1));
      add_tx(0, 5'(20 + i), 32'h2000 + i);
    end
    run_stream(80, full_at);
    chk("full_drained", alu_tx.size() + lsu_tx.size(), 32'd0);
    chk("full_pushes_before_stall", full_at, 32'd7);
    tick(); tick();
    chk("full_count", wr_log.size(), 32'd20);
    li = 0; ai = 0;
    foreach (wr_log[i]) begin
      if (wr_log[i] < 20) begin
        chk("lsu_order", {27'b0, wr_log[i]}, 32'(1 + li)); li++;
      end else begin
        chk("alu_order", {27'b0, wr_log[i]}, 32'(20 + ai)); ai++;
      end
    end

    // x0 write consumes a grant without writing
    do_reset();
    wr_log.delete();
    add_tx(0, 5'd0, 32'hFFFF); add_tx(0, 5'd6, 32'h66);
    add_tx(1, 5'd9, 32'h99);
    chk("x0_alu_ready", {31'b0, alu_ready_o}, 32'd1);
    run_stream(20, full_at);
    tick(); tick();
    chk("x0_count", wr_log.size(), 32'd2);
    if (wr_log.size() == 2) begin
      chk("x0_w0", {27'b0, wr_log[0]}, 32'd9);
      chk("x0_w1", {27'b0, wr_log[1]}, 32'd6);
    end

    // Reset with three loads pending (rd 3,4,5)
    do_reset();
    for (int i = 0; i < 8; i++) begin
      add_tx(1, 5'(1 + i), 32'h300 + i);
      add_tx(0, 5'(20 + i), 32'h400 + i);
    end
    query_rd_i = 5'd5;
    run_stream(5, full_at);
    alu_tx.delete(); lsu_tx.delete();
    chk("mid_hit_before", {31'b0, query_hit_o}, 32'd1);
    chk("mid_we_before", {31'b0, rf_we_o}, 32'd1);
    do_reset();
    wr_log.delete();
    chk("mid_we", {31'b0, rf_we_o}, 32'd0);
    chk("mid_waddr", {27'b0, rf_waddr_o}, 32'd0);
    chk("mid_wdata", rf_wdata_o, 32'd0);
    chk("mid_lsu_ready", {31'b0, lsu_ready_o}, 32'd1);
    chk("mid_alu_ready", {31'b0, alu_ready_o}, 32'd1);
    chk("mid_hit", {31'b0, query_hit_o}, 32'd0);
    tick(); tick(); tick();
    chk("mid_no_stale", wr_log.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
